// File: rtl/edge_detect_multi.sv
// Multi-channel synchronising, debouncing edge detector with selectable edge mode.
// Optional sticky event flags with per-channel clear are enabled by defining EDGE_DET_STICKY_EN.
module edge_detect_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT      = 20000,
    parameter int CW          = $clog2(DB_CNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [CH-1:0] signal,
`ifdef EDGE_DET_STICKY_EN
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] evt_flag,
`endif
    output logic [CH-1:0] level,
    output logic [CH-1:0] edge_pulse,
    output logic [CH-1:0] pos_edge,
    output logic [CH-1:0] neg_edge,
    output logic          evt_any
);

    localparam logic [1:0] LO     = 2'b00;
    localparam logic [1:0] LO_CHK = 2'b01;
    localparam logic [1:0] HI     = 2'b10;
    localparam logic [1:0] HI_CHK = 2'b11;

    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [CH-1:0]          s;
    logic [1:0]             state   [CH];
    logic [1:0]             state_n [CH];
    logic [CW-1:0]          cnt     [CH];
    logic [CW-1:0]          cnt_n   [CH];
    logic [CH-1:0]          pos_n;
    logic [CH-1:0]          neg_n;
    logic [CH-1:0]          edge_n;

    // Bit 1 of the state encoding is the debounced level itself.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign s[g]     = sync_q[g][SYNC_STAGES-1];
        assign level[g] = state[g][1];
    end

    always_comb begin
        pos_n = '0;
        neg_n = '0;
        for (int i = 0; i < CH; i++) begin
            state_n[i] = state[i];
            cnt_n[i]   = '0;
            if (en) begin
                case (state[i])
                    LO: begin
                        if (s[i]) begin
                            if (DB_CNT == 1) begin
                                state_n[i] = HI;
                                pos_n[i]   = 1'b1;
                            end else begin
                                state_n[i] = LO_CHK;
                                cnt_n[i]   = CW'(1);
                            end
                        end
                    end
                    LO_CHK: begin
                        if (!s[i]) begin
                            state_n[i] = LO;
                        end else if (cnt[i] == CW'(DB_CNT - 1)) begin
                            state_n[i] = HI;
                            pos_n[i]   = 1'b1;
                        end else begin
                            cnt_n[i] = cnt[i] + CW'(1);
                        end
                    end
                    HI: begin
                        if (!s[i]) begin
                            if (DB_CNT == 1) begin
                                state_n[i] = LO;
                                neg_n[i]   = 1'b1;
                            end else begin
                                state_n[i] = HI_CHK;
                                cnt_n[i]   = CW'(1);
                            end
                        end
                    end
                    default: begin
                        if (s[i]) begin
                            state_n[i] = HI;
                        end else if (cnt[i] == CW'(DB_CNT - 1)) begin
                            state_n[i] = LO;
                            neg_n[i]   = 1'b1;
                        end else begin
                            cnt_n[i] = cnt[i] + CW'(1);
                        end
                    end
                endcase
            end else begin
                // Disabled: drop any pending qualification but keep the accepted level.
                state_n[i] = {state[i][1], 1'b0};
            end
        end
    end

    always_comb begin
        case (mode)
            2'b00:   edge_n = pos_n;
            2'b01:   edge_n = neg_n;
            2'b10:   edge_n = pos_n | neg_n;
            default: edge_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= '0;
                state[i]  <= LO;
                cnt[i]    <= '0;
            end
            pos_edge   <= '0;
            neg_edge   <= '0;
            edge_pulse <= '0;
            evt_any    <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal[i]};
                state[i]  <= state_n[i];
                cnt[i]    <= cnt_n[i];
            end
            pos_edge   <= pos_n;
            neg_edge   <= neg_n;
            edge_pulse <= edge_n;
            evt_any    <= |edge_n;
        end
    end

`ifdef EDGE_DET_STICKY_EN
    // A new edge outranks a clear landing on the same clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_flag <= '0;
        end else begin
            evt_flag <= edge_n | (evt_flag & ~clr);
        end
    end
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi (CH=4, SYNC_STAGES=2, DB_CNT=3) using an expected-event queue.
// Define EDGE_DET_STICKY_EN for both files to also exercise the sticky flags.
module tb_edge_detect_multi;

    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int DB  = 3;
    localparam int LAT = SS + DB;

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [CH-1:0] signal;
    logic [CH-1:0] level;
    logic [CH-1:0] edge_pulse;
    logic [CH-1:0] pos_edge;
    logic [CH-1:0] neg_edge;
    logic          evt_any;
`ifdef EDGE_DET_STICKY_EN
    logic [CH-1:0] clr;
    logic [CH-1:0] evt_flag;
    logic [CH-1:0] exp_flag;
    logic [CH-1:0] clr_cur;
`endif

    typedef struct {
        int cyc;
        int ch;
        bit rise;
        bit sel;
    } exp_t;

    exp_t          sb [$];
    int            edge_cnt;
    int            total;
    int            bad;
    logic [CH-1:0] exp_level;

    edge_detect_multi #(.CH(CH), .SYNC_STAGES(SS), .DB_CNT(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .signal     (signal),
`ifdef EDGE_DET_STICKY_EN
        .clr        (clr),
        .evt_flag   (evt_flag),
`endif
        .level      (level),
        .edge_pulse (edge_pulse),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .evt_any    (evt_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit exp_sel(input logic [1:0] m, input bit rise);
        case (m)
            2'b00:   return rise;
            2'b01:   return !rise;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, expv, edge_cnt);
        end
    endtask

    task automatic push_at(input int ch, input bit rise, input int delay);
        exp_t e;
        e.cyc  = edge_cnt + delay;
        e.ch   = ch;
        e.rise = rise;
        e.sel  = exp_sel(mode, rise);
        sb.push_back(e);
    endtask

    task automatic push_edge(input int ch, input bit rise);
        push_at(ch, rise, LAT);
    endtask

    task automatic tick();
        logic [CH-1:0] ep;
        logic [CH-1:0] en_exp;
        logic [CH-1:0] ee;
        ep = '0;
        en_exp = '0;
        ee = '0;
`ifdef EDGE_DET_STICKY_EN
        clr_cur = clr;
`endif
        @(posedge clk);
        edge_cnt++;
        #1;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == edge_cnt) begin
                if (sb[k].rise) begin
                    ep[sb[k].ch]        = 1'b1;
                    exp_level[sb[k].ch] = 1'b1;
                end else begin
                    en_exp[sb[k].ch]    = 1'b1;
                    exp_level[sb[k].ch] = 1'b0;
                end
                if (sb[k].sel) ee[sb[k].ch] = 1'b1;
                sb.delete(k);
            end
        end
        check("pos_edge", 8'(pos_edge), 8'(ep));
        check("neg_edge", 8'(neg_edge), 8'(en_exp));
        check("edge_pulse", 8'(edge_pulse), 8'(ee));
        check("evt_any", 8'(evt_any), 8'(|ee));
        check("level", 8'(level), 8'(exp_level));
`ifdef EDGE_DET_STICKY_EN
        exp_flag = ee | (exp_flag & ~clr_cur);
        check("evt_flag", 8'(evt_flag), 8'(exp_flag));
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        edge_cnt  = 0;
        exp_level = '0;
        rst       = 1'b1;
        en        = 1'b1;
        mode      = 2'b00;
        signal    = '0;
`ifdef EDGE_DET_STICKY_EN
        clr      = '0;
        exp_flag = '0;
`endif

        // Reset state and release
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Clean rise on channel 0
        signal[0] = 1'b1;
        push_edge(0, 1'b1);
        repeat (8) tick();

        // Two-cycle glitch on channel 1 is rejected
        signal[1] = 1'b1;
        repeat (2) tick();
        signal[1] = 1'b0;
        repeat (6) tick();

        // Bounce 1-0-1-1-1 gives one rise
        signal[1] = 1'b1;
        tick();
        signal[1] = 1'b0;
        tick();
        signal[1] = 1'b1;
        push_edge(1, 1'b1);
        repeat (8) tick();

        // Mode sweep on channel 2
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            signal[2] = 1'b1;
            push_edge(2, 1'b1);
            repeat (10) tick();
            signal[2] = 1'b0;
            push_edge(2, 1'b0);
            repeat (10) tick();
        end

        // Enable gating on channel 3
        mode = 2'b00;
        en = 1'b0;
        signal[3] = 1'b1;
        repeat (6) tick();
        en = 1'b1;
        push_at(3, 1'b1, DB);
        repeat (6) tick();

        // All channels low, then simultaneous rise
        signal = '0;
        push_edge(0, 1'b0);
        push_edge(1, 1'b0);
        push_edge(3, 1'b0);
        repeat (10) tick();
        signal = 4'b1111;
        for (int c = 0; c < CH; c++) push_edge(c, 1'b1);
        repeat (8) tick();

`ifdef EDGE_DET_STICKY_EN
        // Sticky flags: clear, then clear coinciding with a new edge
        clr[0] = 1'b1;
        tick();
        clr = '0;
        tick();
        mode = 2'b10;
        signal[0] = 1'b0;
        push_edge(0, 1'b0);
        repeat (LAT - 1) tick();
        clr[0] = 1'b1;
        tick();
        clr = '0;
        repeat (3) tick();
        mode = 2'b00;
`endif

        // Reset in the middle of debouncing falls
        signal = '0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("rst_level", 8'(level), 8'h00);
        check("rst_pos", 8'(pos_edge), 8'h00);
        check("rst_edge", 8'(edge_pulse), 8'h00);
        check("rst_any", 8'(evt_any), 8'h00);
        sb.delete();
        exp_level = '0;
`ifdef EDGE_DET_STICKY_EN
        exp_flag = '0;
`endif
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();

        check("sb_empty", 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
